// File: rtl/bf16_addsub_stream_ctrl.sv
// bf16_addsub_stream_ctrl
// Streaming front/back end for a pipelined bfloat16 adder. Operand pairs are
// accepted over valid/ready. A subtract is turned into an add by flipping the
// sign bit of B. The pair is registered onto add_a/add_b. A valid/tag delay
// line matched to the adder latency marks when add_res carries each result,
// and the result is then captured into a show-ahead FIFO. Admission is
// credit based: in-flight plus buffered results never exceed DEPTH, so a
// capture always finds room in the FIFO.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake
//   in_a, in_b            operands
//   in_sub                1 = A-B, 0 = A+B
//   in_tag                user tag, returned with the result
//   add_a, add_b          registered operands to the adder
//   add_res               adder result, LAT edges after add_a/add_b change
//   out_valid/out_ready   result handshake
//   out_data, out_tag     head-of-FIFO result and tag (0 when empty)
//   idle                  nothing in flight and FIFO empty
module bf16_addsub_stream_ctrl #(
  parameter int N     = 16,
  parameter int LAT   = 4,
  parameter int DEPTH = 8,
  parameter int TW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic          in_sub,
  input  logic [TW-1:0] in_tag,
  output logic [N-1:0]  add_a,
  output logic [N-1:0]  add_b,
  input  logic [N-1:0]  add_res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [TW-1:0] out_tag,
  output logic          idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [N-1:0]  add_a_q, add_a_d;
  logic [N-1:0]  add_b_q, add_b_d;
  logic [LAT:0]  dl_v_q, dl_v_d;
  logic [TW-1:0] dl_tag_q [LAT+1];
  logic [TW-1:0] dl_tag_d [LAT+1];
  logic [N-1:0]  mem_data_q [DEPTH];
  logic [N-1:0]  mem_data_d [DEPTH];
  logic [TW-1:0] mem_tag_q [DEPTH];
  logic [TW-1:0] mem_tag_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] pending_q, pending_d;

  logic accept;
  logic pop;
  logic push;

  // Credits come from registered state only, so out_ready never reaches in_ready.
  assign in_ready  = (pending_q < PW'(DEPTH));
  assign idle      = (pending_q == '0);
  assign out_valid = (fifo_cnt_q != '0);
  assign out_data  = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign out_tag   = out_valid ? mem_tag_q[rd_ptr_q]  : '0;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  // The tail of the delay line lines up with the edge at which add_res holds
  // the result of the pair issued LAT+1 edges earlier.
  assign push   = dl_v_q[LAT];

  always_comb begin
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    if (accept) begin
      add_a_d = in_a;
      add_b_d = in_sub ? {~in_b[N-1], in_b[N-2:0]} : in_b;
    end

    dl_v_d      = {dl_v_q[LAT-1:0], accept};
    dl_tag_d[0] = accept ? in_tag : '0;
    for (int i = 1; i <= LAT; i++) begin
      dl_tag_d[i] = dl_tag_q[i-1];
    end

    mem_data_d = mem_data_q;
    mem_tag_d  = mem_tag_q;
    if (push) begin
      mem_data_d[wr_ptr_q] = add_res;
      mem_tag_d[wr_ptr_q]  = dl_tag_q[LAT];
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);

    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + PW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - PW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    pending_d = pending_q;
    case ({accept, pop})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a_q    <= '0;
      add_b_q    <= '0;
      dl_v_q     <= '0;
      for (int i = 0; i <= LAT; i++) begin
        dl_tag_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_tag_q[i]  <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      pending_q  <= '0;
    end else begin
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      dl_v_q     <= dl_v_d;
      dl_tag_q   <= dl_tag_d;
      mem_data_q <= mem_data_d;
      mem_tag_q  <= mem_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_bf16_addsub_stream_ctrl.sv
// Testbench for bf16_addsub_stream_ctrl. The adder is stubbed as a pure
// LAT-edge delay of add_a, so each result equals the A operand of its pair.
module tb_bf16_addsub_stream_ctrl;
  localparam int N     = 16;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_a = '0;
  logic [N-1:0]  in_b = '0;
  logic          in_sub = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic [N-1:0]  add_a;
  logic [N-1:0]  add_b;
  logic [N-1:0]  add_res;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          idle;

  int n_checks = 0;
  int n_fail   = 0;

  bf16_addsub_stream_ctrl #(.N(N), .LAT(LAT), .DEPTH(DEPTH), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .add_a(add_a), .add_b(add_b), .add_res(add_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .idle(idle)
  );

  always #5 clk = ~clk;

  // Adder stub: add_res follows add_a after LAT clock edges; not reset.
  logic [N-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= add_a;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_res = pipe[LAT-1];

  // Outstanding-result model built from the two handshakes.
  int model_pend;
  always @(posedge clk or posedge rst) begin
    if (rst) model_pend <= 0;
    else model_pend <= model_pend + ((in_valid && in_ready) ? 1 : 0)
                                   - ((out_valid && out_ready) ? 1 : 0);
  end
  always @(negedge clk) begin
    if (!rst && model_pend > DEPTH)
      $error("FAIL credit_overflow: outstanding %0d exceeds %0d", model_pend, DEPTH);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #2;
    n_checks++; if (add_a !== 16'h0000) begin $display("FAIL reset_add_a: got %h want 0000", add_a); n_fail++; end
    n_checks++; if (add_b !== 16'h0000) begin $display("FAIL reset_add_b: got %h want 0000", add_b); n_fail++; end
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b want 0", out_valid); n_fail++; end
    n_checks++; if (out_data !== 16'h0000) begin $display("FAIL reset_out_data: got %h want 0000", out_data); n_fail++; end
    n_checks++; if (out_tag !== 4'h0) begin $display("FAIL reset_out_tag: got %h want 0", out_tag); n_fail++; end
    n_checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b want 1", in_ready); n_fail++; end
    n_checks++; if (idle !== 1'b1) begin $display("FAIL reset_idle: got %b want 1", idle); n_fail++; end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1 || idle !== 1'b1) begin $display("FAIL post_reset_ready_idle: got %b/%b want 1/1", in_ready, idle); n_fail++; end
  endtask

  task automatic test_single_add();
    out_ready = 1'b0;
    in_a = 16'h3F80; in_b = 16'h4000; in_sub = 1'b0; in_tag = 4'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (add_a !== 16'h3F80) begin $display("FAIL single_add_a: got %h want 3f80", add_a); n_fail++; end
    n_checks++; if (add_b !== 16'h4000) begin $display("FAIL single_add_b: got %h want 4000", add_b); n_fail++; end
    n_checks++; if (idle !== 1'b0) begin $display("FAIL single_busy: idle got %b want 0", idle); n_fail++; end
    for (int j = 1; j <= LAT; j++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin $display("FAIL single_early_valid: edge %0d got %b want 0", j, out_valid); n_fail++; end
    end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin $display("FAIL single_latency: out_valid got %b want 1", out_valid); n_fail++; end
    n_checks++; if (out_data !== 16'h3F80) begin $display("FAIL single_data: got %h want 3f80", out_data); n_fail++; end
    n_checks++; if (out_tag !== 4'd3) begin $display("FAIL single_tag: got %h want 3", out_tag); n_fail++; end
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h3F80 || out_tag !== 4'd3) begin
      $display("FAIL single_hold: got %b/%h/%h want 1/3f80/3", out_valid, out_data, out_tag); n_fail++; end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000) begin $display("FAIL single_pop: got %b/%h want 0/0000", out_valid, out_data); n_fail++; end
    n_checks++; if (idle !== 1'b1) begin $display("FAIL single_idle: got %b want 1", idle); n_fail++; end
  endtask

  task automatic test_sub_flip();
    logic [N-1:0] vb [3];
    logic         vs [3];
    logic [N-1:0] ve [3];
    int c;
    vb[0] = 16'h3F80; vs[0] = 1'b1; ve[0] = 16'hBF80;
    vb[1] = 16'hC040; vs[1] = 1'b1; ve[1] = 16'h4040;
    vb[2] = 16'hC040; vs[2] = 1'b0; ve[2] = 16'hC040;
    out_ready = 1'b0;
    for (int v = 0; v < 3; v++) begin
      in_a = 16'h1230 + 16'(v); in_b = vb[v]; in_sub = vs[v]; in_tag = TW'(v); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++; if (add_b !== ve[v]) begin $display("FAIL sub_flip_b[%0d]: got %h want %h", v, add_b, ve[v]); n_fail++; end
      n_checks++; if (add_a !== 16'h1230 + 16'(v)) begin $display("FAIL sub_flip_a[%0d]: got %h want %h", v, add_a, 16'h1230 + 16'(v)); n_fail++; end
    end
    out_ready = 1'b1;
    c = 0;
    while (c < 40 && idle !== 1'b1) begin tick(); c++; end
    out_ready = 1'b0;
    n_checks++; if (idle !== 1'b1) begin $display("FAIL sub_flip_drain: idle got %b want 1 within 40 cycles", idle); n_fail++; end
  endtask

  task automatic test_back_pressure();
    int acc;
    acc = 0;
    out_ready = 1'b0;
    for (int t = 0; t < 16; t++) begin
      in_valid = 1'b1; in_a = 16'h4100 + 16'(t); in_b = 16'h0000; in_sub = 1'b0; in_tag = TW'(t);
      if (in_ready === 1'b1) acc++;
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (acc != DEPTH) begin $display("FAIL bp_accepts: got %0d want %0d", acc, DEPTH); n_fail++; end
    n_checks++; if (in_ready !== 1'b0) begin $display("FAIL bp_in_ready_low: got %b want 0", in_ready); n_fail++; end
    n_checks++; if (out_valid !== 1'b1) begin $display("FAIL bp_out_valid: got %b want 1", out_valid); n_fail++; end
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++; if (out_tag !== TW'(k) || out_data !== 16'h4100 + 16'(k)) begin
        $display("FAIL bp_order[%0d]: got %h/%h want %h/%h", k, out_tag, out_data, TW'(k), 16'h4100 + 16'(k)); n_fail++; end
      tick();
      if (k == 0) begin
        n_checks++; if (in_ready !== 1'b1) begin $display("FAIL bp_in_ready_reassert: got %b want 1", in_ready); n_fail++; end
      end
    end
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin $display("FAIL bp_drained: valid/idle got %b/%b want 0/1", out_valid, idle); n_fail++; end
  endtask

  task automatic test_streaming();
    logic [N-1:0] ea, eb;
    out_ready = 1'b1;
    for (int i = 0; i < 100 + LAT + 1; i++) begin
      in_valid = (i < 100);
      in_a = 16'(i * 259 + 7);
      in_b = 16'(i * 4099 + 3);
      in_sub = i[0];
      in_tag = TW'(i);
      ea = in_a;
      eb = in_sub ? (in_b ^ 16'h8000) : in_b;
      if (i < 100) begin
        n_checks++; if (in_ready !== 1'b1) begin $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); n_fail++; end
      end
      tick();
      if (i < 100) begin
        n_checks++; if (add_a !== ea || add_b !== eb) begin
          $display("FAIL stream_issue[%0d]: got %h/%h want %h/%h", i, add_a, add_b, ea, eb); n_fail++; end
      end
      if (i >= LAT + 1) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'((i - LAT - 1) * 259 + 7) || out_tag !== TW'(i - LAT - 1)) begin
          $display("FAIL stream_out[%0d]: got %b/%h/%h want 1/%h/%h", i, out_valid, out_data, out_tag,
                   16'((i - LAT - 1) * 259 + 7), TW'(i - LAT - 1)); n_fail++; end
      end else begin
        n_checks++; if (out_valid !== 1'b0) begin $display("FAIL stream_early[%0d]: got %b want 0", i, out_valid); n_fail++; end
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin $display("FAIL stream_end: valid/idle got %b/%b want 0/1", out_valid, idle); n_fail++; end
  endtask

  task automatic test_concurrency();
    int c;
    out_ready = 1'b0;
    in_a = 16'h1111; in_b = 16'h0000; in_sub = 1'b0; in_tag = 4'd1; in_valid = 1'b1;
    tick();
    in_a = 16'h2222; in_tag = 4'd2;
    tick();
    in_valid = 1'b0;
    repeat (LAT) tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h1111 || out_tag !== 4'd1) begin
      $display("FAIL conc_first: got %b/%h/%h want 1/1111/1", out_valid, out_data, out_tag); n_fail++; end
    // Pop A, capture B and accept C on one edge.
    in_a = 16'h3333; in_tag = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h2222 || out_tag !== 4'd2) begin
      $display("FAIL conc_swap: got %b/%h/%h want 1/2222/2", out_valid, out_data, out_tag); n_fail++; end
    n_checks++; if (idle !== 1'b0) begin $display("FAIL conc_busy: idle got %b want 0", idle); n_fail++; end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || idle !== 1'b0) begin $display("FAIL conc_no_dup: valid/idle got %b/%b want 0/0", out_valid, idle); n_fail++; end
    c = 0;
    while (c < 20 && out_valid !== 1'b1) begin tick(); c++; end
    n_checks++; if (c != LAT || out_data !== 16'h3333 || out_tag !== 4'd3) begin
      $display("FAIL conc_third: waited %0d want %0d, got %h/%h want 3333/3", c, LAT, out_data, out_tag); n_fail++; end
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin $display("FAIL conc_end: valid/idle got %b/%b want 0/1", out_valid, idle); n_fail++; end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      in_valid = 1'b1; in_a = 16'hA000 + 16'(t); in_b = 16'h0000; in_sub = 1'b0; in_tag = TW'(t + 4);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'hA000) begin
      $display("FAIL rmid_pre: got %b/%h want 1/a000", out_valid, out_data); n_fail++; end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000) begin $display("FAIL rmid_out: got %b/%h want 0/0000", out_valid, out_data); n_fail++; end
    n_checks++; if (idle !== 1'b1 || in_ready !== 1'b1) begin $display("FAIL rmid_idle: idle/in_ready got %b/%b want 1/1", idle, in_ready); n_fail++; end
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 2 * LAT + 4; c++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin $display("FAIL rmid_stale[%0d]: out_valid got %b want 0", c, out_valid); n_fail++; end
    end
    in_a = 16'h5A5A; in_tag = 4'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int j = 1; j <= LAT; j++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin $display("FAIL rmid_early[%0d]: got %b want 0", j, out_valid); n_fail++; end
    end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h5A5A || out_tag !== 4'd9) begin
      $display("FAIL rmid_new: got %b/%h/%h want 1/5a5a/9", out_valid, out_data, out_tag); n_fail++; end
    tick();
    out_ready = 1'b0;
    n_checks++; if (idle !== 1'b1) begin $display("FAIL rmid_end_idle: got %b want 1", idle); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub_flip();
    test_back_pressure();
    test_streaming();
    test_concurrency();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
